interrupt_controller: RTL
=========================

# interrupt_controller

Upstream neighbour of the CPU control unit: owns the Game Boy IF (0xFF0F) and IE (0xFFFF) registers and the interrupt master enable (IME). It latches peripheral requests, applies priority, and presents a one-hot serviceable interrupt to the control unit. It clears the serviced IF bit on acknowledge and supplies the handler vector. It also implements the EI one-instruction delay and the HALT wake condition.

## Interface
Parameters:
- NUM_IRQ, 5, interrupt sources (0 VBlank, 1 LCD STAT, 2 Timer, 3 Serial, 4 Joypad); bit 0 highest priority

Ports:
- i_Clk  in  1  system clock, all state on rising edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Requests  in  NUM_IRQ  peripheral request levels; each high cycle sets the matching IF bit
- i_Addr  in  16  CPU bus address
- i_Data  in  8  CPU write data
- i_Write  in  1  write strobe, one cycle
- i_Read  in  1  read strobe, one cycle
- o_Data  out  8  read data, registered
- o_Data_Valid  out  1  high the cycle after a decoded read
- i_EI  in  1  EI executed, one-cycle pulse
- i_DI  in  1  DI executed, one-cycle pulse
- i_RETI  in  1  RETI executed, one-cycle pulse
- i_Instr_Boundary  in  1  pulse on every opcode fetch (IR write step)
- i_Ack  in  1  control unit begins servicing, one-cycle pulse
- o_Interrupts  out  NUM_IRQ  one-hot highest-priority pending & enabled interrupt, gated by IME; drives control unit i_Interrupts
- o_Wake  out  1  (IF & IE) != 0, independent of IME (HALT exit)
- o_Vector  out  8  handler address low byte of last acknowledged interrupt
- o_IME  out  1  current master enable

## Operation
- Reset: IF=0, IE=0, IME=0, EI sequencer IDLE, o_Vector=8'h00, o_Data=0, o_Data_Valid=0. o_Interrupts and o_Wake are combinational and therefore 0.
- IF next-state: `(wr_IF ? i_Data[4:0] : IF) & ~ack_mask | i_Requests`.
  - Peripheral set wins over ack clear and CPU write in the same cycle.
- IE: all 8 bits stored; only bits [4:0] qualify interrupts.
- Reads:
  - IF returns {3'b111, IF}; IE returns the stored 8 bits.
  - Other addresses: no response, o_Data_Valid stays 0.
  - Data is registered, so it reflects state before any same-cycle write.
- Selection: pending = IF & IE[4:0]; o_Interrupts = IME ? lowest-set-bit(pending) : 0.
- Acknowledge:
  - On i_Ack, ack_mask = o_Interrupts of that cycle.
  - Clear that IF bit and clear IME.
  - Latch o_Vector = 8'h40 + 8*index.
  - i_Ack with o_Interrupts==0 leaves IF unchanged and sets o_Vector=8'h00 (cancelled dispatch, control unit jumps to 0x0000).
- EI sequencer, states IDLE, ARMED, WAIT:
  - i_EI: any state -> ARMED.
  - ARMED + i_Instr_Boundary -> WAIT (fetch of the instruction after EI).
  - WAIT + i_Instr_Boundary -> IDLE with IME<=1.
  - i_DI: IME<=0 and state -> IDLE; it overrides i_EI in the same cycle.
  - i_RETI: IME<=1 immediately, state -> IDLE.
  - i_Ack: IME<=0 and state -> IDLE.
  - Priority, highest first: i_Ack, i_DI, i_RETI, i_EI, boundary.
- EI;EI: the second EI re-arms, so IME rises after the instruction that follows the second EI.

## Timing
- Request to o_Interrupts/o_Wake: 1 cycle (IF register), combinational after that.
- IE/IF write to effect: next cycle.
- Ack: IF bit clear, IME=0, and o_Vector valid in the cycle after i_Ack; o_Interrupts drops in that same cycle.
- Read latency 1 cycle; o_Data holds its value until the next decoded read.
- Reset asserted mid-sequence: everything returns to reset values immediately; no pending EI survives.

## Structure
- Shared package gb_interrupt_pkg:
  - IF_ADDR=16'hFF0F, IE_ADDR=16'hFFFF, VECTOR_BASE=8'h40, VECTOR_STRIDE=8
  - IRQ index constants
  - EI sequencer state enum
- One sub-module: ime_sequencer (EI/DI/RETI/Ack/boundary -> IME, 3-state FSM).
- Priority encoder stays inline.

## Test plan
- Reset then IE=8'h1F, pulse i_Requests=5'b00100 with IME=0 -> o_Wake=1, o_Interrupts=0; read IF -> 8'hE4.
- IE=1F, IME=1, requests 5'b10110 -> o_Interrupts=5'b00010; i_Ack -> IF=5'b10100, IME=0, o_Vector=8'h48.
- i_EI, then boundary, then boundary -> IME stays 0 until the second boundary and is 1 the cycle after it; i_DI between the boundaries -> IME stays 0.
- Same cycle: CPU writes IF=0 and i_Requests[0]=1 -> IF=5'b00001; ack of bit 2 together with i_Requests[2] -> bit 2 stays set.
- IF pending bit cleared by a CPU write before i_Ack -> o_Vector=8'h00, IF unchanged.
- Reset asserted while the sequencer is in WAIT with IE=8'hFF -> IME=0, IE=0, IF=0, o_Vector=0, and no IME rise on later boundaries.

Source files
------------

// File: rtl/gb_interrupt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_interrupt_pkg
// Description : Shared constants and types for the Game Boy interrupt block:
//               register addresses, vector geometry, IRQ indices and the
//               EI-delay sequencer state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package gb_interrupt_pkg;

    localparam logic [15:0] IF_ADDR       = 16'hFF0F;
    localparam logic [15:0] IE_ADDR       = 16'hFFFF;
    localparam logic [7:0]  VECTOR_BASE   = 8'h40;
    localparam int          VECTOR_STRIDE = 8;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    // EI takes effect only after the instruction following it has been fetched
    typedef enum logic [1:0] {
        EI_IDLE  = 2'd0,
        EI_ARMED = 2'd1,
        EI_WAIT  = 2'd2
    } ei_state_t;

endpackage
`default_nettype wire

// File: rtl/ime_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ime_sequencer
// Description : Interrupt master enable with the EI one-instruction delay.
//               Ack, DI, RETI, EI and instruction boundaries are resolved in
//               that priority order.
// Revision    : 1.0  initial release
// ============================================================================
module ime_sequencer (
    input  logic i_Clk,
    input  logic i_Reset_n,
    input  logic i_EI,
    input  logic i_DI,
    input  logic i_RETI,
    input  logic i_Ack,
    input  logic i_Instr_Boundary,
    output logic o_IME
);
    import gb_interrupt_pkg::*;

    ei_state_t r_state;
    logic      r_ime;

    // IME and EI-delay state machine; registered output
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= EI_IDLE;
            r_ime   <= 1'b0;
        end else if (i_Ack) begin
            r_state <= EI_IDLE;
            r_ime   <= 1'b0;
        end else if (i_DI) begin
            r_state <= EI_IDLE;
            r_ime   <= 1'b0;
        end else if (i_RETI) begin
            r_state <= EI_IDLE;
            r_ime   <= 1'b1;
        end else if (i_EI) begin
            // A repeated EI restarts the delay from scratch
            r_state <= EI_ARMED;
        end else if (i_Instr_Boundary) begin
            case (r_state)
                EI_ARMED: r_state <= EI_WAIT;
                EI_WAIT: begin
                    r_state <= EI_IDLE;
                    r_ime   <= 1'b1;
                end
                default:  r_state <= EI_IDLE;
            endcase
        end
    end

    assign o_IME = r_ime;

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Game Boy IF/IE registers, fixed-priority selection, acknowledge
//               handling with vector latch, HALT wake and IME sequencing.
// Revision    : 1.0  initial release
// ============================================================================
module interrupt_controller #(
    parameter int NUM_IRQ = 5
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    input  logic [NUM_IRQ-1:0] i_Requests,
    input  logic [15:0]        i_Addr,
    input  logic [7:0]         i_Data,
    input  logic               i_Write,
    input  logic               i_Read,
    output logic [7:0]         o_Data,
    output logic               o_Data_Valid,
    input  logic               i_EI,
    input  logic               i_DI,
    input  logic               i_RETI,
    input  logic               i_Instr_Boundary,
    input  logic               i_Ack,
    output logic [NUM_IRQ-1:0] o_Interrupts,
    output logic               o_Wake,
    output logic [7:0]         o_Vector,
    output logic               o_IME
);
    import gb_interrupt_pkg::*;

    logic [NUM_IRQ-1:0] r_if;
    logic [7:0]         r_ie;
    logic [7:0]         r_vector;
    logic [7:0]         r_data;
    logic               r_data_valid;

    logic               w_sel_if;
    logic               w_sel_ie;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_irq;
    logic [NUM_IRQ-1:0] w_ack_mask;
    logic [NUM_IRQ-1:0] w_if_base;
    logic [7:0]         w_vector;

    assign w_sel_if  = (i_Addr == IF_ADDR);
    assign w_sel_ie  = (i_Addr == IE_ADDR);
    assign w_pending = r_if & r_ie[NUM_IRQ-1:0];

    // Two's-complement trick isolates the lowest set bit (bit 0 = highest priority)
    assign w_irq        = o_IME ? (w_pending & (~w_pending + NUM_IRQ'(1))) : '0;
    assign o_Interrupts = w_irq;
    assign o_Wake       = |w_pending;
    assign w_ack_mask   = i_Ack ? w_irq : '0;
    assign w_if_base    = (i_Write && w_sel_if) ? i_Data[NUM_IRQ-1:0] : r_if;

    // Handler address of the selected source; zero when nothing is selected
    always_comb begin
        w_vector = 8'h00;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_irq[i]) begin
                w_vector = VECTOR_BASE + 8'(i * VECTOR_STRIDE);
            end
        end
    end

    // IF/IE storage; a peripheral request always wins over clear and CPU write
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_if <= '0;
            r_ie <= 8'h00;
        end else begin
            r_if <= (w_if_base & ~w_ack_mask) | i_Requests;
            if (i_Write && w_sel_ie) begin
                r_ie <= i_Data;
            end
        end
    end

    // Vector latch on acknowledge; a cancelled dispatch yields 0x00
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_vector <= 8'h00;
        end else if (i_Ack) begin
            r_vector <= w_vector;
        end
    end

    // Registered read port; data holds until the next decoded read
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_data       <= 8'h00;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= i_Read && (w_sel_if || w_sel_ie);
            if (i_Read && w_sel_if) begin
                r_data <= {{(8-NUM_IRQ){1'b1}}, r_if};
            end else if (i_Read && w_sel_ie) begin
                r_data <= r_ie;
            end
        end
    end

    assign o_Vector     = r_vector;
    assign o_Data       = r_data;
    assign o_Data_Valid = r_data_valid;

    ime_sequencer u_ime_sequencer (
        .i_Clk            (i_Clk),
        .i_Reset_n        (i_Reset_n),
        .i_EI             (i_EI),
        .i_DI             (i_DI),
        .i_RETI           (i_RETI),
        .i_Ack            (i_Ack),
        .i_Instr_Boundary (i_Instr_Boundary),
        .o_IME            (o_IME)
    );

endmodule
`default_nettype wire
